m_memarb: RTL and testbench

Two-port arbiter that shares one single-port synchronous `m_memory` instance (4K x 32, registered read, 1-cycle latency) between the instruction-fetch requester (I, read-only) and the data requester (D, load/store). It sits between the processor pipeline and a unified memory. It decides each cycle which requester drives the memory address/write port, tags the issued read, and returns read data with a valid strobe one cycle later. Data wins by default; an optional anti-starvation counter guarantees fetch progress.

---
 rtl/m_memarb.sv | 83 ++++++++
 tb/tb_m_memarb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_memarb.sv
// m_memarb: shares one single-port synchronous memory between fetch (I) and data (D) requesters.
// Optional MEMARB_STARVE_EN forces an I grant after STARVE_MAX consecutive denied cycles.
module m_memarb #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_ireq,
  input  logic [ADDR_W-1:0] w_iaddr,
  output logic              w_igrant,
  output logic              r_ivalid,
  output logic [DATA_W-1:0] w_irdata,
  input  logic              w_dreq,
  input  logic              w_dwe,
  input  logic [ADDR_W-1:0] w_daddr,
  input  logic [DATA_W-1:0] w_dwdata,
  output logic              w_dgrant,
  output logic              r_dvalid,
  output logic [DATA_W-1:0] w_drdata,
  output logic [ADDR_W-1:0] w_maddr,
  output logic              w_mwe,
  output logic [DATA_W-1:0] w_mdin,
  input  logic [DATA_W-1:0] w_mdout,
  output logic [3:0]        r_istarve
);

  localparam int unsigned     CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef MEMARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic w_force_i;

  // Starvation only overrides D priority when the feature is built in
  assign w_force_i = STARVE_EN && (r_istarve >= CNT_W'(STARVE_MAX));

  // Owner selection and memory port mux; everything idles low during reset
  always_comb begin
    w_igrant = 1'b0;
    w_dgrant = 1'b0;
    w_maddr  = '0;
    w_mwe    = 1'b0;
    w_mdin   = '0;
    if (!w_rst) begin
      if (w_ireq && (!w_dreq || w_force_i)) begin
        w_igrant = 1'b1;
        w_maddr  = w_iaddr;
      end else if (w_dreq) begin
        w_dgrant = 1'b1;
        w_maddr  = w_daddr;
        w_mwe    = w_dwe;
        w_mdin   = w_dwdata;
      end
    end
  end

  // Read tags line up with the memory's one-cycle registered read
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_ivalid  <= 1'b0;
      r_dvalid  <= 1'b0;
      r_istarve <= '0;
    end else begin
      r_ivalid <= w_igrant;
      r_dvalid <= w_dgrant & ~w_dwe;
      if (w_ireq && !w_igrant) begin
        if (r_istarve != CNT_MAX) r_istarve <= r_istarve + CNT_W'(1);
      end else begin
        r_istarve <= '0;
      end
    end
  end

  assign w_irdata = w_mdout;
  assign w_drdata = w_mdout;

endmodule

// File: tb/tb_m_memarb.sv
// tb_m_memarb: randomized self-checking bench for m_memarb with a behavioural memory and model.
// Expectations follow MEMARB_STARVE_EN the same way the design build does.
module tb_m_memarb;

  localparam int unsigned AW         = 12;
  localparam int unsigned DW         = 32;
  localparam int unsigned STARVE_MAX = 4;
`ifdef MEMARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ireq, dreq, dwe;
  logic [AW-1:0] iaddr, daddr;
  logic [DW-1:0] dwdata;
  logic          igrant, ivalid, dgrant, dvalid, mwe;
  logic [DW-1:0] irdata, drdata, mdin, mdout;
  logic [AW-1:0] maddr;
  logic [3:0]    istarve;

  m_memarb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .w_clk(clk), .w_rst(rst),
    .w_ireq(ireq), .w_iaddr(iaddr), .w_igrant(igrant), .r_ivalid(ivalid), .w_irdata(irdata),
    .w_dreq(dreq), .w_dwe(dwe), .w_daddr(daddr), .w_dwdata(dwdata),
    .w_dgrant(dgrant), .r_dvalid(dvalid), .w_drdata(drdata),
    .w_maddr(maddr), .w_mwe(mwe), .w_mdin(mdin), .w_mdout(mdout),
    .r_istarve(istarve)
  );

  always #5 clk = ~clk;

  // Stand-in for the 4K x 32 registered-read memory
  logic [DW-1:0] mem [4096];
  always @(posedge clk) begin
    if (mwe) mem[maddr] <= mdin;
    mdout <= mem[maddr];
  end

  // Reference model state
  logic [DW-1:0] ref_mem [4096];
  logic          pend_i, pend_d;
  logic [DW-1:0] pend_data;
  logic [3:0]    m_starve;
  logic          exp_ig, exp_dg, exp_iv, exp_dv, exp_mwe;
  logic [AW-1:0] exp_maddr;
  logic [DW-1:0] exp_rdata;
  logic [3:0]    exp_st;
  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;

  task automatic reset_model();
    pend_i = 1'b0; pend_d = 1'b0; pend_data = '0; m_starve = '0;
  endtask

  // Apply one cycle of requests at the negedge and derive expectations from the rules
  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic we,
                       input logic [AW-1:0] da, input logic [DW-1:0] dd);
    @(negedge clk);
    cyc++;
    ireq = ir; iaddr = ia; dreq = dr; dwe = we; daddr = da; dwdata = dd;
    #1;
    exp_iv = pend_i; exp_dv = pend_d; exp_rdata = pend_data; exp_st = m_starve;
    if (ir && (!dr || (STARVE_EN && (int'(m_starve) >= int'(STARVE_MAX))))) begin
      exp_ig = 1'b1; exp_dg = 1'b0;
    end else begin
      exp_ig = 1'b0; exp_dg = dr;
    end
    exp_maddr = exp_ig ? ia : (exp_dg ? da : '0);
    exp_mwe   = exp_dg & we;
  endtask

  // Advance the model past the coming posedge
  task automatic commit();
    pend_i    = exp_ig;
    pend_d    = exp_dg & ~dwe;
    pend_data = ref_mem[exp_maddr];
    if (exp_mwe) ref_mem[exp_maddr] = dwdata;
    if (ireq && !exp_ig) m_starve = (m_starve == 4'd15) ? 4'd15 : m_starve + 4'd1;
    else m_starve = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ireq = 1'b1; dreq = 1'b1; dwe = 1'b1; iaddr = 12'h3; daddr = 12'h4; dwdata = 32'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({igrant, dgrant, ivalid, dvalid, mwe, istarve} !== 9'b0 || maddr !== '0 || mdin !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got g=%b%b v=%b%b we=%b st=%0d a=%h d=%h want all zero",
               igrant, dgrant, ivalid, dvalid, mwe, istarve, maddr, mdin);
    end
    @(negedge clk);
    ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
    rst = 1'b0;
    reset_model();
  endtask

  task automatic test_i_read();
    for (int k = 0; k < 3; k++) begin
      drive(k == 0, 12'd5, 1'b0, 1'b0, '0, '0);
      n_chk++;
      if ({igrant, dgrant, ivalid, dvalid, istarve, maddr, mwe} !== {exp_ig, exp_dg, exp_iv, exp_dv, exp_st, exp_maddr, exp_mwe}) begin
        n_fail++;
        $display("FAIL i_read cyc=%0d got g=%b%b v=%b%b st=%0d a=%h we=%b want g=%b%b v=%b%b st=%0d a=%h we=%b",
                 cyc, igrant, dgrant, ivalid, dvalid, istarve, maddr, mwe,
                 exp_ig, exp_dg, exp_iv, exp_dv, exp_st, exp_maddr, exp_mwe);
      end
      if (k == 1) begin
        n_chk++;
        if (ivalid !== 1'b1 || irdata !== 32'h1234) begin
          n_fail++;
          $display("FAIL i_read_data got v=%b d=%h want v=1 d=00001234", ivalid, irdata);
        end
      end
      commit();
    end
  endtask

  task automatic test_store_load();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, k < 2, k == 0, 12'd7, (k == 0) ? 32'hDEAD : 32'h0);
      n_chk++;
      if ({igrant, dgrant, ivalid, dvalid, maddr, mwe} !== {exp_ig, exp_dg, exp_iv, exp_dv, exp_maddr, exp_mwe}
          || (exp_mwe && mdin !== dwdata)) begin
        n_fail++;
        $display("FAIL store_load cyc=%0d got g=%b%b v=%b%b a=%h we=%b din=%h want g=%b%b v=%b%b a=%h we=%b",
                 cyc, igrant, dgrant, ivalid, dvalid, maddr, mwe, mdin,
                 exp_ig, exp_dg, exp_iv, exp_dv, exp_maddr, exp_mwe);
      end
      if (k == 2) begin
        n_chk++;
        if (dvalid !== 1'b1 || drdata !== 32'hDEAD) begin
          n_fail++;
          $display("FAIL store_load_raw got v=%b d=%h want v=1 d=0000dead", dvalid, drdata);
        end
      end
      commit();
    end
  endtask

  task automatic test_starvation();
    logic [AW-1:0] ia = 12'd40;
    int ig_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, ia, 1'b1, 1'b0, AW'($urandom_range(100, 200)), '0);
      n_chk++;
      if ({igrant, dgrant, ivalid, dvalid, istarve, maddr} !== {exp_ig, exp_dg, exp_iv, exp_dv, exp_st, exp_maddr}) begin
        n_fail++;
        $display("FAIL starvation cyc=%0d got g=%b%b v=%b%b st=%0d a=%h want g=%b%b v=%b%b st=%0d a=%h",
                 cyc, igrant, dgrant, ivalid, dvalid, istarve, maddr,
                 exp_ig, exp_dg, exp_iv, exp_dv, exp_st, exp_maddr);
      end
      if (exp_iv || exp_dv) begin
        n_chk++;
        if ((exp_iv ? irdata : drdata) !== exp_rdata) begin
          n_fail++;
          $display("FAIL starvation_data cyc=%0d got %h want %h", cyc, exp_iv ? irdata : drdata, exp_rdata);
        end
      end
      if (igrant === 1'b1) begin
        ig_cnt++;
        ia = ia + 12'd1;
      end
      commit();
    end
    n_chk++;
    if (ig_cnt != (STARVE_EN ? 4 : 0)) begin
      n_fail++;
      $display("FAIL starvation_igrant_count got %0d want %0d", ig_cnt, STARVE_EN ? 4 : 0);
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    commit();
  endtask

  task automatic test_async_reset();
    // Read issued, reset pulsed mid-cycle before the edge: no strobe may follow
    drive(1'b1, 12'd9, 1'b0, 1'b0, '0, '0);
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if ({igrant, dgrant, ivalid, dvalid, mwe, istarve} !== 9'b0 || maddr !== '0) begin
      n_fail++;
      $display("FAIL async_reset_mid got g=%b%b v=%b%b we=%b st=%0d a=%h want all zero",
               igrant, dgrant, ivalid, dvalid, mwe, istarve, maddr);
    end
    rst = 1'b0; ireq = 1'b0;
    reset_model();
    // Reset landing while a strobe is already up clears it immediately
    drive(1'b1, 12'd9, 1'b0, 1'b0, '0, '0);
    commit();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if (ivalid !== 1'b0 || igrant !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_inflight got v=%b g=%b want v=0 g=0", ivalid, igrant);
    end
    ireq = 1'b0;
    #1 rst = 1'b0;
    reset_model();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
      n_chk++;
      if ({ivalid, dvalid, istarve} !== {exp_iv, exp_dv, exp_st} || exp_iv !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset_after cyc=%0d got v=%b%b st=%0d want v=00 st=0", cyc, ivalid, dvalid, istarve);
      end
      commit();
    end
  endtask

  task automatic test_back_to_back();
    int iv_cnt = 0, dv_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      drive(k < 8 && k % 2 == 0, AW'(20 + k), k < 8 && k % 2 == 1, 1'b0, AW'(20 + k), '0);
      n_chk++;
      if ({igrant, dgrant, ivalid, dvalid, maddr} !== {exp_ig, exp_dg, exp_iv, exp_dv, exp_maddr}) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d got g=%b%b v=%b%b a=%h want g=%b%b v=%b%b a=%h",
                 cyc, igrant, dgrant, ivalid, dvalid, maddr, exp_ig, exp_dg, exp_iv, exp_dv, exp_maddr);
      end
      if (exp_iv || exp_dv) begin
        n_chk++;
        if ((exp_iv ? irdata : drdata) !== exp_rdata) begin
          n_fail++;
          $display("FAIL back_to_back_data cyc=%0d got %h want %h", cyc, exp_iv ? irdata : drdata, exp_rdata);
        end
      end
      iv_cnt += int'(ivalid === 1'b1);
      dv_cnt += int'(dvalid === 1'b1);
      commit();
    end
    n_chk++;
    if (iv_cnt != 4 || dv_cnt != 4) begin
      n_fail++;
      $display("FAIL back_to_back_counts got i=%0d d=%0d want i=4 d=4", iv_cnt, dv_cnt);
    end
  endtask

  task automatic test_random();
    logic          ip = 1'b0, dp = 1'b0, we = 1'b0;
    logic [AW-1:0] ia = '0, da = '0;
    logic [DW-1:0] dd = '0;
    for (int k = 0; k < 200; k++) begin
      if (!ip) begin ip = 1'($urandom_range(0, 1)); ia = AW'($urandom_range(0, 15)); end
      if (!dp) begin
        dp = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
        da = AW'($urandom_range(0, 15)); dd = $urandom;
      end
      drive(ip, ia, dp, we, da, dd);
      n_chk++;
      if ({igrant, dgrant, ivalid, dvalid, istarve, maddr, mwe} !== {exp_ig, exp_dg, exp_iv, exp_dv, exp_st, exp_maddr, exp_mwe}
          || (exp_mwe && mdin !== dd)) begin
        n_fail++;
        $display("FAIL random cyc=%0d got g=%b%b v=%b%b st=%0d a=%h we=%b want g=%b%b v=%b%b st=%0d a=%h we=%b",
                 cyc, igrant, dgrant, ivalid, dvalid, istarve, maddr, mwe,
                 exp_ig, exp_dg, exp_iv, exp_dv, exp_st, exp_maddr, exp_mwe);
      end
      if (exp_iv || exp_dv) begin
        n_chk++;
        if ((exp_iv ? irdata : drdata) !== exp_rdata) begin
          n_fail++;
          $display("FAIL random_data cyc=%0d got %h want %h", cyc, exp_iv ? irdata : drdata, exp_rdata);
        end
      end
      if (exp_ig) ip = 1'b0;
      if (exp_dg) dp = 1'b0;
      commit();
    end
  endtask

  initial begin
    rst = 1'b1;
    ireq = 1'b0; dreq = 1'b0; dwe = 1'b0; iaddr = '0; daddr = '0; dwdata = '0;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[5] = 32'h1234;
    ref_mem[5] = 32'h1234;
    reset_model();
    test_reset();
    test_i_read();
    test_store_load();
    test_starvation();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
